// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Also holds the combinational frame decode used by the top level.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          LED_W     = 16;
  localparam int          PAT_W     = 2;
  localparam logic [3:0]  LAST_STEP = 4'd8;

  localparam logic [PAT_W-1:0] PAT_BAR   = 2'd0;
  localparam logic [PAT_W-1:0] PAT_FILL  = 2'd1;
  localparam logic [PAT_W-1:0] PAT_BLINK = 2'd2;
  localparam logic [PAT_W-1:0] PAT_CHASE = 2'd3;

  // Frame for pattern pat at step 0..8. Done in 32 bits so the 2k-wide
  // run of ones at k=8 (and shifts of 16) never overflow before truncation.
  function automatic logic [LED_W-1:0] led_frame(input logic [PAT_W-1:0] pat,
                                                 input logic [3:0]       step);
    logic [31:0] ones;
    logic [31:0] f;
    logic [4:0]  sh2;
    sh2  = {step, 1'b0};
    ones = (32'd1 << sh2) - 32'd1;
    f    = 32'd0;
    case (pat)
      PAT_BAR:   f = ones << (32'd8 - 32'(step));
      PAT_FILL:  f = ones << (32'd16 - 32'(sh2));
      PAT_BLINK: f = step[0] ? 32'd0 : 32'h0000_FFFF;
      PAT_CHASE: f = (step < LAST_STEP) ? (32'd3 << sh2) : 32'd0;
      default:   f = 32'd0;
    endcase
    return f[LED_W-1:0];
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while enabled, one-cycle tick
// on the terminal count. Sync clear restarts the step period.
module led_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise wrap on tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Arbitrates NUM_REQ requesters onto one 16-LED bar and plays the granted
// requester's 9-step pattern, holds the last frame, pulses done.
// Optional macro LED_SEQ_ROUND_ROBIN_EN: round-robin arbitration instead of
// fixed priority (req[0] highest).
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int NUM_REQ    = 4,
  parameter int HOLD_STEPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done,
  output logic [LED_W-1:0]   led
);

  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PAT_W-1:0]   pat_q, pat_d;

  logic             tick;
  logic             req_any;
  logic [PAT_W-1:0] sel;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   ((state_q == RUN) || (state_q == HOLD)),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

`ifdef LED_SEQ_ROUND_ROBIN_EN
  logic [PAT_W-1:0] last_q, last_d;

  // Round-robin pick: first set request after the last granted index
  always_comb begin
    int idx;
    req_any = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        sel     = PAT_W'(idx);
      end
    end
  end

  // Remember the owner so the next search starts just past it
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && req_any) last_d = sel;
  end

  // Last-granted register; reset so the first search starts at index 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PAT_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end
`else
  // Fixed priority pick: lowest set index wins
  always_comb begin
    req_any = 1'b0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_any && req[i]) begin
        req_any = 1'b1;
        sel     = PAT_W'(i);
      end
    end
  end
`endif

  // Sequencer next-state: grant in IDLE, step on ticks, hold, one-cycle DONE
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = ONE_HOT0 << sel;
          pat_d   = sel;
          step_d  = '0;
          hold_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          if (step_q == LAST_STEP) begin
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) state_d = DONE;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      pat_q   <= pat_d;
    end
  end

  // Outputs decode straight from registered state; LEDs dark outside RUN/HOLD
  always_comb begin
    grant = grant_q;
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    led   = '0;
    if (state_q == RUN || state_q == HOLD) led = led_frame(pat_q, step_q);
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench: dut1 at TICK_DIV=4/HOLD_STEPS=2, dut2 at TICK_DIV=1/HOLD_STEPS=1.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [3:0]  req, req2;
  logic [3:0]  grant, grant2;
  logic        busy, busy2, done, done2;
  logic [15:0] led, led2;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.TICK_DIV(4), .NUM_REQ(4), .HOLD_STEPS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .busy(busy), .done(done), .led(led)
  );

  led_pattern_sequencer #(.TICK_DIV(1), .NUM_REQ(4), .HOLD_STEPS(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .grant(grant2),
    .busy(busy2), .done(done2), .led(led2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to offset n cycles after the current grant
  task automatic at(input int n);
    if (n > t) tick(n - t);
    t = n;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      tick(1);
      n++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  logic [15:0] chase_tbl [0:8] = '{16'h0003, 16'h000C, 16'h0030, 16'h00C0,
                                   16'h0300, 16'h0C00, 16'h3000, 16'hC000, 16'h0000};
  logic [15:0] blink_tbl [0:9] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF,
                                   16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; req = '0; req2 = '0;
    tick(2);
    chk("rst_grant", {28'd0, grant}, 32'h0);
    chk("rst_busy",  {31'd0, busy},  32'h0);
    chk("rst_done",  {31'd0, done},  32'h0);
    chk("rst_led",   {16'd0, led},   32'h0);
    chk("rst_led2",  {16'd0, led2},  32'h0);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick(1);
    chk("idle_grant", {28'd0, grant}, 32'h0);

    // P0 centre-out bar, one-cycle request
    req = 4'b0001;
    tick(1); t = 0;
    chk("p0_grant", {28'd0, grant}, 32'h1);
    chk("p0_busy",  {31'd0, busy},  32'h1);
    chk("p0_s0",    {16'd0, led},   32'h0000);
    req = '0;
    at(3);  chk("p0_t3",  {16'd0, led}, 32'h0000);
    at(4);  chk("p0_t4",  {16'd0, led}, 32'h0180);
    at(8);  chk("p0_t8",  {16'd0, led}, 32'h03C0);
    at(12); chk("p0_t12", {16'd0, led}, 32'h07E0);
    at(32); chk("p0_t32", {16'd0, led}, 32'hFFFF);
    at(43); chk("p0_t43", {16'd0, led}, 32'hFFFF);
            chk("p0_nodone", {31'd0, done}, 32'h0);
    at(44); chk("p0_done", {31'd0, done}, 32'h1);
            chk("p0_dled", {16'd0, led}, 32'h0);
            chk("p0_dgnt", {28'd0, grant}, 32'h1);
    at(45); chk("p0_idle_done", {31'd0, done}, 32'h0);
            chk("p0_idle_gnt", {28'd0, grant}, 32'h0);
            chk("p0_idle_busy", {31'd0, busy}, 32'h0);

    // Simultaneous requests, held across a full sequence
    req = 4'b1110;
    tick(1); t = 0;
    chk("sim_grant", {28'd0, grant}, 32'h2);
    at(4);  chk("p1_t4",  {16'd0, led}, 32'hC000);
    at(16); chk("p1_t16", {16'd0, led}, 32'hFF00);
    at(44); chk("p1_done", {31'd0, done}, 32'h1);
    at(45); chk("p1_idle_gnt", {28'd0, grant}, 32'h0);
    at(46);
`ifdef LED_SEQ_ROUND_ROBIN_EN
    chk("regrant", {28'd0, grant}, 32'h4);
`else
    chk("regrant", {28'd0, grant}, 32'h2);
`endif
    req = '0;
    wait_done(100);
    tick(1);

    // P3 chase, request dropped at g+5
    req = 4'b1000;
    tick(1); t = 0;
    chk("p3_grant", {28'd0, grant}, 32'h8);
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) begin
        at(5);
        req = '0;
      end
      at(4 * k);
      chk($sformatf("p3_s%0d", k), {16'd0, led}, {16'd0, chase_tbl[k]});
    end
    at(35); chk("p3_t35", {16'd0, led}, 32'h0000);
    at(43); chk("p3_nodone", {31'd0, done}, 32'h0);
    at(44); chk("p3_done", {31'd0, done}, 32'h1);
    at(45);

    // Mid-sequence reset with request held
    req = 4'b0001;
    tick(1); t = 0;
    chk("rs_grant", {28'd0, grant}, 32'h1);
    at(20); chk("rs_t20", {16'd0, led}, 32'h1FF8);
    rst_n = 1'b0;
    #1;
    chk("rs_led",   {16'd0, led},   32'h0);
    chk("rs_grant0", {28'd0, grant}, 32'h0);
    chk("rs_busy",  {31'd0, busy},  32'h0);
    chk("rs_done",  {31'd0, done},  32'h0);
    tick(1);
    chk("rs_hold_done", {31'd0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("rs_regrant", {28'd0, grant}, 32'h1);
    chk("rs_rebusy",  {31'd0, busy},  32'h1);
    req = '0;
    wait_done(100);
    tick(1);

    // TICK_DIV=1, HOLD_STEPS=1 blink
    req2 = 4'b0100;
    tick(1);
    chk("bl_grant", {28'd0, grant2}, 32'h4);
    req2 = '0;
    for (int c = 0; c <= 9; c++) begin
      chk($sformatf("bl_c%0d", c), {16'd0, led2}, {16'd0, blink_tbl[c]});
      chk($sformatf("bl_nd%0d", c), {31'd0, done2}, 32'h0);
      tick(1);
    end
    chk("bl_done", {31'd0, done2}, 32'h1);
    chk("bl_dled", {16'd0, led2},  32'h0);
    tick(1);
    chk("bl_idle", {31'd0, busy2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
